// File: rtl/debug_display_sequencer_pkg.sv
// Shared package for the debug display sequencer.
// Holds the display mode encoding, the "display error" word, and the index of
// each probe channel. Whoever packs the flattened ch_data bus uses the channel
// indices below, so the channel numbers on the HEX display stay consistent
// across builds.
package dbg_pkg;

    // Encoding of the 2-bit mode input.
    typedef enum logic [1:0] {
        DBG_MANUAL  = 2'd0,
        DBG_SCAN    = 2'd1,
        DBG_FREEZE  = 2'd2,
        DBG_HISTORY = 2'd3
    } dbg_mode_e;

    // Shown for an invalid selection or an empty history slot ("dEdE").
    localparam logic [31:0] DBG_DEFAULT_VAL = 32'h0000_DEDE;

    // Probe channel map.
    localparam int CH_STAGE  = 0;   // pipeline stage counter
    localparam int CH_PC     = 1;   // program counter
    localparam int CH_IR     = 2;   // instruction register
    localparam int CH_RA     = 3;
    localparam int CH_RB     = 4;
    localparam int CH_RZ     = 5;
    localparam int CH_RM     = 6;
    localparam int CH_RY     = 7;
    localparam int CH_CCR    = 8;   // condition code register
    localparam int CH_EN     = 9;   // packed datapath enables
    localparam int CH_MUXSEL = 10;  // packed mux selects
    localparam int CH_CCR_IN = 11;  // condition codes feeding the CCR

endpackage

// File: rtl/debug_history_buffer.sv
// Circular history of captured probe words.
// Each write lands at wr_ptr, which then advances and wraps at HIST_DEPTH.
// hist_count tracks how many entries hold data and saturates at HIST_DEPTH.
// The read port is indexed relative to the newest entry: rd_idx = 0 is the
// last word written, rd_idx = 1 the one before it, and so on.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   wr_en, wr_data   capture strobe and word to store
//   rd_idx           entry to read, 0 = newest
//   rd_data          word at rd_idx (combinational)
//   rd_valid         1 when rd_idx refers to a written entry
//   hist_count       number of valid entries, 0..HIST_DEPTH
module debug_history_buffer #(
    parameter int DATA_W     = 32,
    parameter int HIST_DEPTH = 8,
    localparam int HI_W      = $clog2(HIST_DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [HI_W-1:0]   rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [HI_W:0]     hist_count
);

    localparam logic [HI_W:0] COUNT_FULL = (HI_W+1)'(HIST_DEPTH);

    logic [DATA_W-1:0] mem [HIST_DEPTH];
    logic [HI_W-1:0]   wr_ptr;
    logic [HI_W-1:0]   rd_addr;

    // Storage has no reset: hist_count gates what is visible.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            hist_count <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;   // HIST_DEPTH is a power of two: natural wrap
            if (hist_count != COUNT_FULL)
                hist_count <= hist_count + 1'b1;
        end
    end

    // Newest entry sits one behind wr_ptr; the subtraction wraps modulo HIST_DEPTH.
    assign rd_addr  = wr_ptr - HI_W'(1) - rd_idx;
    assign rd_data  = mem[rd_addr];
    assign rd_valid = ({1'b0, rd_idx} < hist_count);

endmodule

// File: rtl/debug_display_sequencer.sv
// Debug display sequencer: picks one probe word for the 32-bit HEX display.
// Modes: MANUAL (manual_sel), SCAN (step through enabled channels, SCAN_DWELL
// clocks each), FREEZE (hold the word shown on entry), HISTORY (view words
// captured on step pulses). override_en beats every mode for the display word
// only; scan, freeze and history state keep evolving underneath it.
// Every output is registered: display_out reflects inputs from the previous edge.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   ch_data          flattened probes, channel k at [k*DATA_W +: DATA_W]
//   ch_en_mask       per-channel enable for scan/manual display
//   mode             0 MANUAL, 1 SCAN, 2 FREEZE, 3 HISTORY
//   manual_sel       channel for MANUAL mode and for history capture
//   step             stage-advance pulse, captures history outside HISTORY mode
//   hist_idx         history entry to view, 0 = newest
//   override_en/data highest-priority display source
//   display_out      registered display word
//   display_sel      channel being shown (scan_sel in SCAN, else manual_sel)
//   frozen           1 while FREEZE holds its captured word
//   hist_count       valid history entries, saturating at HIST_DEPTH
module debug_display_sequencer
    import dbg_pkg::*;
#(
    parameter int NUM_CH      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_W       = 5,
    parameter int SCAN_DWELL  = 50_000_000,
    parameter int HIST_DEPTH  = 8,
    parameter logic [DATA_W-1:0] DEFAULT_VAL = DATA_W'(DBG_DEFAULT_VAL),
    localparam int HI_W       = $clog2(HIST_DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_en_mask,
    input  logic [1:0]               mode,
    input  logic [SEL_W-1:0]         manual_sel,
    input  logic                     step,
    input  logic [HI_W-1:0]          hist_idx,
    input  logic                     override_en,
    input  logic [DATA_W-1:0]        override_data,
    output logic [DATA_W-1:0]        display_out,
    output logic [SEL_W-1:0]         display_sel,
    output logic                     frozen,
    output logic [HI_W:0]            hist_count
);

    // Channels padded out to the full select range so any select value can
    // index directly; padded slots have a zero mask bit and so read as invalid.
    localparam int CH_PAD = 1 << SEL_W;
    localparam int DW_W   = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DWELL - 1);

    logic [DATA_W-1:0] ch_arr [CH_PAD];
    logic [CH_PAD-1:0] mask_ext;

    dbg_mode_e          cur_mode;
    dbg_mode_e          prev_mode;
    logic [SEL_W-1:0]   scan_sel;
    logic [SEL_W-1:0]   next_sel;
    logic [SEL_W-1:0]   cand;
    logic               found;
    logic [DW_W-1:0]    dwell;
    logic [DATA_W-1:0]  freeze_val;

    logic [DATA_W-1:0]  manual_word;
    logic [DATA_W-1:0]  scan_word;
    logic [DATA_W-1:0]  hist_word;
    logic [DATA_W-1:0]  hist_rd_data;
    logic               hist_rd_valid;
    logic               hist_wr_en;
    logic               mode_changed;
    logic               freeze_entry;
    logic               scan_sel_ok;

    for (genvar k = 0; k < CH_PAD; k++) begin : g_ch
        if (k < NUM_CH) begin : g_real
            assign ch_arr[k] = ch_data[k*DATA_W +: DATA_W];
        end else begin : g_pad
            assign ch_arr[k] = '0;
        end
    end

    assign mask_ext = CH_PAD'(ch_en_mask);
    assign cur_mode = dbg_mode_e'(mode);

    assign mode_changed = (cur_mode != prev_mode);
    assign freeze_entry = (cur_mode == DBG_FREEZE) && (prev_mode != DBG_FREEZE);
    assign scan_sel_ok  = mask_ext[scan_sel];

    assign manual_word = mask_ext[manual_sel] ? ch_arr[manual_sel] : DEFAULT_VAL;
    assign scan_word   = scan_sel_ok          ? ch_arr[scan_sel]   : DEFAULT_VAL;
    assign hist_word   = hist_rd_valid        ? hist_rd_data       : DEFAULT_VAL;

    // Step is gated by the mode currently presented, so a step arriving on the
    // same cycle HISTORY is selected does not disturb the buffer being viewed.
    assign hist_wr_en = step && (cur_mode != DBG_HISTORY);

    // Next enabled channel above scan_sel, wrapping NUM_CH-1 -> 0. The search
    // covers the full ring, so a single enabled channel finds itself again.
    always_comb begin
        next_sel = scan_sel;
        cand     = scan_sel;
        found    = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = SEL_W'((int'(scan_sel) + i) % NUM_CH);
            if (!found && mask_ext[cand]) begin
                found    = 1'b1;
                next_sel = cand;
            end
        end
    end

    debug_history_buffer #(
        .DATA_W     (DATA_W),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (hist_wr_en),
        .wr_data    (manual_word),
        .rd_idx     (hist_idx),
        .rd_data    (hist_rd_data),
        .rd_valid   (hist_rd_valid),
        .hist_count (hist_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            display_out <= '0;
            display_sel <= '0;
            frozen      <= 1'b0;
            scan_sel    <= '0;
            dwell       <= '0;
            prev_mode   <= DBG_MANUAL;
            freeze_val  <= '0;
        end else begin
            prev_mode <= cur_mode;
            frozen    <= (cur_mode == DBG_FREEZE);

            // Scan state runs whether or not override is active.
            if (mode_changed) begin
                dwell <= '0;
            end else if (cur_mode == DBG_SCAN) begin
                if (mask_ext == '0) begin
                    dwell <= '0;                  // nothing to scan: hold scan_sel
                end else if (!scan_sel_ok || dwell == DWELL_LAST) begin
                    scan_sel <= next_sel;         // disabled channel skips at once
                    dwell    <= '0;
                end else begin
                    dwell <= dwell + 1'b1;
                end
            end

            // Snapshot kept apart from display_out so an override during
            // FREEZE does not replace the held word.
            if (freeze_entry)
                freeze_val <= display_out;

            display_sel <= (cur_mode == DBG_SCAN) ? scan_sel : manual_sel;

            if (override_en) begin
                display_out <= override_data;
            end else begin
                case (cur_mode)
                    DBG_MANUAL:  display_out <= manual_word;
                    DBG_SCAN:    display_out <= scan_word;
                    DBG_FREEZE:  display_out <= freeze_entry ? display_out : freeze_val;
                    DBG_HISTORY: display_out <= hist_word;
                    default:     display_out <= DEFAULT_VAL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debug_display_sequencer.sv
// Directed bench for debug_display_sequencer with 28 channels, 4-clock scan
// dwell and 8-entry history. Inputs change 1 time unit after a rising edge;
// outputs are sampled at the same point, after the edge that consumed them.
module tb_debug_display_sequencer;

    localparam int NUM_CH     = 28;
    localparam int DATA_W     = 32;
    localparam int SEL_W      = 5;
    localparam int SCAN_DWELL = 4;
    localparam int HIST_DEPTH = 8;
    localparam int HI_W       = $clog2(HIST_DEPTH);
    localparam logic [31:0] DEDE = 32'h0000_DEDE;
    localparam logic [NUM_CH-1:0] ALL_EN = '1;

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b0;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic [NUM_CH-1:0]        ch_en_mask = '0;
    logic [1:0]               mode = 2'd0;
    logic [SEL_W-1:0]         manual_sel = '0;
    logic                     step = 1'b0;
    logic [HI_W-1:0]          hist_idx = '0;
    logic                     override_en = 1'b0;
    logic [DATA_W-1:0]        override_data = '0;
    logic [DATA_W-1:0]        display_out;
    logic [SEL_W-1:0]         display_sel;
    logic                     frozen;
    logic [HI_W:0]            hist_count;

    int total = 0;
    int bad   = 0;

    debug_display_sequencer #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .SEL_W      (SEL_W),
        .SCAN_DWELL (SCAN_DWELL),
        .HIST_DEPTH (HIST_DEPTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ch_data       (ch_data),
        .ch_en_mask    (ch_en_mask),
        .mode          (mode),
        .manual_sel    (manual_sel),
        .step          (step),
        .hist_idx      (hist_idx),
        .override_en   (override_en),
        .override_data (override_data),
        .display_out   (display_out),
        .display_sel   (display_sel),
        .frozen        (frozen),
        .hist_count    (hist_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [31:0] v);
        ch_data[k*DATA_W +: DATA_W] = v;
    endtask

    // Tick until display_sel moves into s from another value; bounded.
    task automatic wait_into(input logic [SEL_W-1:0] s, input string tag);
        logic [SEL_W-1:0] last;
        bit hit;
        last = display_sel;
        hit  = 1'b0;
        for (int n = 0; n < 40 && !hit; n++) begin
            tick();
            if (display_sel == s && last != s) hit = 1'b1;
            last = display_sel;
        end
        if (!hit) chk(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NUM_CH; k++) set_ch(k, 32'h1000_0000 + k);
        ch_en_mask = ALL_EN;

        // Reset state
        #12;
        chk("rst_out",    display_out,       32'd0);
        chk("rst_sel",    32'(display_sel),  32'd0);
        chk("rst_frozen", 32'(frozen),       32'd0);
        chk("rst_hcnt",   32'(hist_count),   32'd0);
        #2 reset_n = 1'b1;
        tick();

        // MANUAL selections
        manual_sel = 5'd3; set_ch(3, 32'h0000_0033);
        tick();
        chk("man_ch3",     display_out,      32'h0000_0033);
        chk("man_ch3_sel", 32'(display_sel), 32'd3);
        manual_sel = 5'd27;
        tick();
        chk("man_ch27", display_out, 32'h1000_001B);

        // Invalid selections
        manual_sel = 5'd31;
        tick();
        chk("inv_sel31", display_out, DEDE);
        manual_sel = 5'd28;
        tick();
        chk("inv_sel28", display_out, DEDE);
        manual_sel = 5'd4; ch_en_mask[4] = 1'b0;
        tick();
        chk("inv_mask4", display_out, DEDE);
        ch_en_mask = ALL_EN;

        // Empty history shows the error word
        mode = 2'd3; hist_idx = '0;
        tick();
        chk("hist_empty", display_out, DEDE);

        // Freeze
        mode = 2'd0; manual_sel = 5'd1; set_ch(1, 32'h100);
        tick();
        chk("frz_pre", display_out, 32'h100);
        mode = 2'd2; set_ch(1, 32'h200);
        tick();
        chk("frz_entry",  display_out, 32'h100);
        chk("frz_flag",   32'(frozen), 32'd1);
        tick();
        chk("frz_hold",   display_out, 32'h100);
        override_en = 1'b1; override_data = 32'hCAFE;
        tick();
        chk("frz_ovr",    display_out, 32'hCAFE);
        override_en = 1'b0;
        tick();
        chk("frz_after_ovr", display_out, 32'h100);
        mode = 2'd0;
        tick();
        chk("frz_exit",   display_out, 32'h200);
        chk("frz_clear",  32'(frozen), 32'd0);

        // Override in MANUAL
        override_en = 1'b1;
        tick();
        chk("ovr_manual", display_out, 32'hCAFE);
        override_en = 1'b0;

        // Scan over channels 0, 2, 5
        set_ch(0, 32'h1000); set_ch(2, 32'h1002); set_ch(5, 32'h1005);
        ch_en_mask = NUM_CH'(32'h25);
        mode = 2'd1;
        wait_into(5'd2, "scan_to2");
        chk("scan2_out", display_out, 32'h1002);
        for (int i = 0; i < 3; i++) begin tick(); chk("scan2_hold", 32'(display_sel), 32'd2); end
        tick();
        chk("scan5_sel", 32'(display_sel), 32'd5);
        chk("scan5_out", display_out, 32'h1005);
        for (int i = 0; i < 3; i++) begin tick(); chk("scan5_hold", 32'(display_sel), 32'd5); end
        tick();
        chk("scan0_sel", 32'(display_sel), 32'd0);
        chk("scan0_out", display_out, 32'h1000);

        // Empty mask in SCAN
        ch_en_mask = '0;
        tick(); tick();
        chk("scan_nomask", display_out, DEDE);

        // Override during SCAN: scan advances underneath
        ch_en_mask = NUM_CH'(32'h25);
        wait_into(5'd2, "ovr_scan_to2");
        override_en = 1'b1; override_data = 32'hCAFE;
        for (int i = 0; i < 6; i++) begin tick(); chk("ovr_scan", display_out, 32'hCAFE); end
        override_en = 1'b0;
        tick();
        chk("ovr_resume_sel", 32'(display_sel), 32'd5);
        chk("ovr_resume_out", display_out, 32'h1005);

        // Asynchronous reset mid-scan
        #3 reset_n = 1'b0;
        #1;
        chk("rst_mid_out", display_out,      32'd0);
        chk("rst_mid_sel", 32'(display_sel), 32'd0);
        mode = 2'd0; manual_sel = 5'd3; ch_en_mask = ALL_EN; set_ch(3, 32'hA5A5);
        #3 reset_n = 1'b1;
        tick();
        chk("rst_rel_out", display_out, 32'hA5A5);
        chk("rst_rel_hcnt", 32'(hist_count), 32'd0);

        // History capture and wrap: values 1..10
        for (int v = 1; v <= 10; v++) begin
            set_ch(3, 32'(v)); step = 1'b1;
            tick();
            step = 1'b0;
        end
        chk("hist_count", 32'(hist_count), 32'd8);
        mode = 2'd3; hist_idx = 3'd0;
        tick();
        chk("hist_idx0", display_out, 32'd10);
        hist_idx = 3'd7;
        tick();
        chk("hist_idx7", display_out, 32'd3);
        hist_idx = 3'd2;
        tick();
        chk("hist_idx2", display_out, 32'd8);
        set_ch(3, 32'h77); step = 1'b1;
        tick(); tick();
        step = 1'b0; hist_idx = 3'd0;
        tick();
        chk("hist_step_ign", display_out, 32'd10);
        chk("hist_cnt_ign",  32'(hist_count), 32'd8);
        override_en = 1'b1;
        tick();
        chk("ovr_hist", display_out, 32'hCAFE);
        override_en = 1'b0;
        tick();
        chk("hist_after_ovr", display_out, 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
